// File: rtl/wb_resp_pkg.sv
// Shared types and constants for the Wishbone register responder.
package wb_resp_pkg;

   // Responder FSM: IDLE accepts, WAIT burns latency, RESP drives ack/err.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_state_e;

   // Value returned by register 0 when the ID register is enabled.
   localparam logic [31:0] WB_RESP_ID = 32'hCA11_0001;

endpackage

// File: rtl/wb_resp_regfile.sv
// Register array for the responder: one write port, one combinational read
// port, and a synchronous reset that clears every word.
module wb_resp_regfile
   import wb_resp_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   localparam logic [31:0] NREGS_W = 32'(NREGS);

   logic [31:0] regs_q [NREGS];
   logic [31:0] regs_d [NREGS];

   // Next register contents: a single word updated when the write port fires.
   always_comb begin
      regs_d = regs_q;
      if (i_we && (32'(i_waddr) < NREGS_W)) begin
         regs_d[i_waddr] = i_wdata;
      end
   end

   // Register storage, cleared on reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational read; indices past the array (non power-of-two sizes) read 0.
   always_comb begin
      o_rdata = '0;
      if (32'(i_raddr) < NREGS_W) begin
         o_rdata = regs_q[i_raddr];
      end
   end

endmodule

// File: rtl/wb_reg_responder.sv
// Wishbone pipelined-style register responder with a fixed response latency.
// Optional feature macro: WB_REG_RESPONDER_ID_EN makes register 0 a read-only
// ID word (reads return WB_RESP_ID, writes respond with err).
//
// Handshake: a request is accepted on a rising edge where i_wb_cyc, i_wb_stb
// and !o_wb_stall are all high; that is the only transfer point. Exactly one
// of o_wb_ack/o_wb_err pulses for one cycle LATENCY cycles after acceptance
// unless i_wb_cyc drops first (abort) or i_reset intervenes; o_wb_data is
// only meaningful while o_wb_ack is high and is 0 otherwise.
module wb_reg_responder
   import wb_resp_pkg::*;
#(
   parameter int NREGS   = 16,
   parameter int LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_stall,
   output logic        o_wb_ack,
   output logic        o_wb_err,
   output logic [31:0] o_wb_data,
   output wb_state_e   o_dbg_state
);

   localparam int          AW       = $clog2(NREGS);
   localparam logic [31:0] NREGS_W  = 32'(NREGS);
   localparam logic [2:0]  CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
`ifdef WB_REG_RESPONDER_ID_EN
   localparam bit          ID_EN    = 1'b1;
`else
   localparam bit          ID_EN    = 1'b0;
`endif

   wb_state_e   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic        accept;
   logic        resp_live;
   logic        bad_req;
   logic        is_id_reg;
   logic        wr_en;
   logic [31:0] reg_rdata;

   assign o_wb_stall  = (state_q != IDLE);
   assign accept      = i_wb_cyc && i_wb_stb && !o_wb_stall;
   assign o_dbg_state = state_q;

   // Response qualification: out-of-range addresses and ID-register writes err.
   always_comb begin
      is_id_reg = ID_EN && (addr_q == 32'd0);
      bad_req   = (addr_q >= NREGS_W) || (is_id_reg && we_q);
      // Dropping cyc or asserting reset in the RESP cycle suppresses the pulse.
      resp_live = (state_q == RESP) && i_wb_cyc && !i_reset;
      o_wb_ack  = resp_live && !bad_req;
      o_wb_err  = resp_live && bad_req;
      wr_en     = o_wb_ack && we_q;
      o_wb_data = '0;
      if (o_wb_ack && !we_q) begin
         o_wb_data = is_id_reg ? WB_RESP_ID : reg_rdata;
      end
   end

   // Next-state logic: latch on accept, count down in WAIT, abort on cyc drop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d   = i_wb_we;
               addr_d = i_wb_addr;
               data_d = i_wb_data;
               if (LATENCY > 1) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (!i_wb_cyc) begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end else if (cnt_q == 3'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // State and request registers; reset wins over any in-flight request.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   wb_resp_regfile #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_we    (wr_en),
      .i_waddr (addr_q[AW-1:0]),
      .i_wdata (data_q),
      .i_raddr (addr_q[AW-1:0]),
      .o_rdata (reg_rdata)
   );

endmodule
